// File: rtl/flipflop_bank_if.sv
// Signal bundle between the flip-flop bank and whatever drives its inputs
// and reads its state. The master drives the mode and per-bit controls.
// The slave (the bank) returns state and status.
interface flipflop_bank_if #(
  parameter int WIDTH = 4
);

  logic [1:0]       Mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Setn;
  logic [WIDTH-1:0] Clrn;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_n;
  logic             Tick;
  logic [WIDTH-1:0] Changed;
  logic [WIDTH-1:0] Illegal;

  modport master (
    output Mode, J, K, Setn, Clrn,
    input  Q, Q_n, Tick, Changed, Illegal
  );

  modport slave (
    input  Mode, J, K, Setn, Clrn,
    output Q, Q_n, Tick, Changed, Illegal
  );

endinterface

// File: rtl/flipflop_bank.sv
// Bank of WIDTH flip-flops with a run-time selectable JK / D / T / SR mode.
// An internal divider produces a one-cycle update tick every DIV cycles.
// Q only advances on tick edges, so the whole block runs on CLK with no
// derived clocks. Change strobes and SR illegal-input flags trail each
// update by one cycle.
module flipflop_bank #(
  parameter int               WIDTH = 4,
  parameter int               DIV   = 12_500_000,
  parameter int               CNT_W = 24,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  flipflop_bank_if.slave    ff_bus
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  // Terminal count of the divider; with DIV=1 it is 0 and every cycle ticks.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_changed;
  logic [WIDTH-1:0] r_illegal;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_illegal;
  mode_e            w_mode;

  // Next value of one bit. Preset beats clear, and both beat the mode logic.
  function automatic logic f_bit_next(
    input mode_e mode,
    input logic  j,
    input logic  k,
    input logic  setn,
    input logic  clrn,
    input logic  q
  );
    logic nxt;
    nxt = q;
    if (!setn) begin
      nxt = 1'b1;
    end else if (!clrn) begin
      nxt = 1'b0;
    end else begin
      unique case (mode)
        MODE_JK: begin
          unique case ({j, k})
            2'b00:   nxt = q;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            default: nxt = ~q;
          endcase
        end
        MODE_D:  nxt = j;
        MODE_T:  nxt = q ^ j;
        default: begin
          // SR: S=R=1 is treated as hold and reported separately.
          unique case ({j, k})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            default: nxt = q;
          endcase
        end
      endcase
    end
    return nxt;
  endfunction

  // S=R=1 in SR mode is only meaningful when no preset/clear overrides it.
  function automatic logic f_bit_illegal(
    input mode_e mode,
    input logic  j,
    input logic  k,
    input logic  setn,
    input logic  clrn
  );
    return (mode == MODE_SR) && setn && clrn && j && k;
  endfunction

  assign w_mode = mode_e'(ff_bus.Mode);

  // Per-bit next state and illegal flag from the current inputs.
  always_comb begin
    w_q_next  = r_q;
    w_illegal = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_q_next[i]  = f_bit_next(w_mode, ff_bus.J[i], ff_bus.K[i],
                                ff_bus.Setn[i], ff_bus.Clrn[i], r_q[i]);
      w_illegal[i] = f_bit_illegal(w_mode, ff_bus.J[i], ff_bus.K[i],
                                   ff_bus.Setn[i], ff_bus.Clrn[i]);
    end
  end

  // Divider: counts 0..DIV-1 and wraps; reset restarts the period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + LP_ONE;
    end
  end

  // Registered tick: high for the single cycle after the terminal count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == LP_LAST);
    end
  end

  // State update on tick edges; status strobes describe that update next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q       <= INIT;
      r_changed <= '0;
      r_illegal <= '0;
    end else if (r_tick) begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
      r_illegal <= w_illegal;
    end else begin
      r_changed <= '0;
      r_illegal <= '0;
    end
  end

  assign ff_bus.Q       = r_q;
  assign ff_bus.Q_n     = ~r_q;
  assign ff_bus.Tick    = r_tick;
  assign ff_bus.Changed = r_changed;
  assign ff_bus.Illegal = r_illegal;

endmodule

// File: tb/tb_flipflop_bank.sv
// Bench for flipflop_bank: three instances (DIV=1, 4, 8) share one set of
// inputs and have separate resets. A vector-level reference model predicts
// every output every cycle; directed sequences cover the timing and
// priority corner cases, followed by a randomized run.
module tb_flipflop_bank;

  localparam logic [3:0] INIT_A = 4'h0;
  localparam logic [3:0] INIT_B = 4'h6;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [1:0] mode;
  logic [3:0] j, k, setn, clrn;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  flipflop_bank_if #(.WIDTH(4)) bus1 ();
  flipflop_bank_if #(.WIDTH(4)) bus4 ();
  flipflop_bank_if #(.WIDTH(4)) bus8 ();

  assign bus1.Mode = mode; assign bus1.J = j; assign bus1.K = k;
  assign bus1.Setn = setn; assign bus1.Clrn = clrn;
  assign bus4.Mode = mode; assign bus4.J = j; assign bus4.K = k;
  assign bus4.Setn = setn; assign bus4.Clrn = clrn;
  assign bus8.Mode = mode; assign bus8.J = j; assign bus8.K = k;
  assign bus8.Setn = setn; assign bus8.Clrn = clrn;

  flipflop_bank #(.WIDTH(4), .DIV(1), .CNT_W(4), .INIT(INIT_A)) u_ff1 (
    .CLK(clk), .RST(rst_v[0]), .ff_bus(bus1));
  flipflop_bank #(.WIDTH(4), .DIV(4), .CNT_W(4), .INIT(INIT_B)) u_ff4 (
    .CLK(clk), .RST(rst_v[1]), .ff_bus(bus4));
  flipflop_bank #(.WIDTH(4), .DIV(8), .CNT_W(4), .INIT(INIT_B)) u_ff8 (
    .CLK(clk), .RST(rst_v[2]), .ff_bus(bus8));

  // Reference model state, one slot per instance.
  int         m_div [3] = '{1, 4, 8};
  int         m_n   [3];
  bit         m_ok  [3];
  logic       m_tick[3];
  logic [3:0] m_q   [3];
  logic [3:0] m_chg [3];
  logic [3:0] m_ill [3];
  logic [3:0] m_qn;

  // Whole-vector characteristic equations, then preset/clear masks on top.
  function automatic logic [3:0] model_next(input logic [1:0] md, input logic [3:0] jj,
                                            input logic [3:0] kk, input logic [3:0] sn,
                                            input logic [3:0] cn, input logic [3:0] q);
    logic [3:0] r;
    case (md)
      2'd0:    r = (jj & ~q) | (~kk & q);
      2'd1:    r = jj;
      2'd2:    r = q ^ jj;
      default: r = (jj & ~kk) | (q & ~(jj ^ kk));
    endcase
    return (r & cn) | ~sn;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin
        m_n[i] = 0; m_tick[i] = 1'b0; m_chg[i] = '0; m_ill[i] = '0; m_ok[i] = 1'b1;
        m_q[i] = (i == 0) ? INIT_A : INIT_B;
      end else begin
        if (m_tick[i]) begin
          m_qn     = model_next(mode, j, k, setn, clrn, m_q[i]);
          m_chg[i] = m_qn ^ m_q[i];
          m_ill[i] = (mode == 2'd3) ? (j & k & setn & clrn) : 4'h0;
          m_q[i]   = m_qn;
        end else begin
          m_chg[i] = '0;
          m_ill[i] = '0;
        end
        m_n[i]    = m_n[i] + 1;
        m_tick[i] = ((m_n[i] % m_div[i]) == 0);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_inst(input string nm, input int i, input logic [3:0] q,
                            input logic [3:0] qn, input logic tk,
                            input logic [3:0] ch, input logic [3:0] il);
    if (m_ok[i]) begin
      check_eq({nm, ".Q"},       {28'd0, q},  {28'd0, m_q[i]});
      check_eq({nm, ".Q_n"},     {28'd0, qn}, {28'd0, ~m_q[i]});
      check_eq({nm, ".Tick"},    {31'd0, tk}, {31'd0, m_tick[i]});
      check_eq({nm, ".Changed"}, {28'd0, ch}, {28'd0, m_chg[i]});
      check_eq({nm, ".Illegal"}, {28'd0, il}, {28'd0, m_ill[i]});
    end
  endtask

  // One clock; outputs are compared against the model on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_inst("div1", 0, bus1.Q, bus1.Q_n, bus1.Tick, bus1.Changed, bus1.Illegal);
    check_inst("div4", 1, bus4.Q, bus4.Q_n, bus4.Tick, bus4.Changed, bus4.Illegal);
    check_inst("div8", 2, bus8.Q, bus8.Q_n, bus8.Tick, bus8.Changed, bus8.Illegal);
  endtask

  task automatic wait_tick4(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cyc();
      seen = bus4.Tick;
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  int         first4, first8, ticks4;
  logic [3:0] exp_q;

  initial begin
    rst_v = 3'b111;
    mode = 2'd0; j = 4'hF; k = 4'hF; setn = 4'hF; clrn = 4'hF;

    // Reset: Q=INIT and Q_n=~INIT while held.
    cyc(); cyc();
    check_eq("rst.div4.Q",    {28'd0, bus4.Q},    {28'd0, INIT_B});
    check_eq("rst.div4.Q_n",  {28'd0, bus4.Q_n},  32'h9);
    check_eq("rst.div1.Q",    {28'd0, bus1.Q},    32'h0);
    check_eq("rst.div8.Tick", {31'd0, bus8.Tick}, 32'd0);

    // Release: tick schedule and JK toggling with DIV=1.
    rst_v = 3'b000;
    first4 = 0; first8 = 0; ticks4 = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (bus4.Tick === 1'b1) begin
        if (first4 == 0) first4 = c;
        ticks4++;
      end
      if (bus8.Tick === 1'b1 && first8 == 0) first8 = c;
      if (c == 2) begin
        check_eq("jk.toggle1.Q",   {28'd0, bus1.Q},       32'hF);
        check_eq("jk.toggle1.chg", {28'd0, bus1.Changed}, 32'hF);
      end
      if (c == 3) begin
        check_eq("jk.toggle2.Q",   {28'd0, bus1.Q},       32'h0);
        check_eq("jk.toggle2.chg", {28'd0, bus1.Changed}, 32'hF);
      end
    end
    check_eq("div4.first_tick", first4, 32'd4);
    check_eq("div4.tick_count", ticks4, 32'd3);
    check_eq("div8.first_tick", first8, 32'd8);

    // JK set/clear, then hold.
    j = 4'h5; k = 4'hA; cyc();
    check_eq("jk.setclr.Q", {28'd0, bus1.Q}, 32'h5);
    j = 4'h0; k = 4'h0; cyc();
    check_eq("jk.hold.Q",   {28'd0, bus1.Q},       32'h5);
    check_eq("jk.hold.chg", {28'd0, bus1.Changed}, 32'h0);

    // Preset beats clear on bit 0; other bits toggle.
    setn = 4'hE; clrn = 4'hE; j = 4'hF; k = 4'hF; cyc();
    check_eq("prio.Q", {28'd0, bus1.Q}, 32'hB);

    // SR mode with one illegal bit, then D mode.
    setn = 4'hF; clrn = 4'hF; mode = 2'd3; j = 4'h3; k = 4'h6; cyc();
    check_eq("sr.Q",   {28'd0, bus1.Q},       32'hB);
    check_eq("sr.ill", {28'd0, bus1.Illegal}, 32'h2);
    mode = 2'd1; j = 4'h9; k = 4'h0; cyc();
    check_eq("d.Q",     {28'd0, bus1.Q},       32'h9);
    check_eq("d.ill",   {28'd0, bus1.Illegal}, 32'h0);

    // DIV=4: J/K pulsed between ticks must not affect Q.
    mode = 2'd0; j = 4'h0; k = 4'h0;
    wait_tick4("div4.wait1");
    cyc();
    exp_q = m_q[1];
    j = 4'hF; k = 4'hF; cyc();
    j = 4'h0; k = 4'h0; cyc();
    wait_tick4("div4.wait2");
    cyc();
    check_eq("div4.pulse.Q",   {28'd0, bus4.Q},       {28'd0, exp_q});
    check_eq("div4.pulse.chg", {28'd0, bus4.Changed}, 32'h0);

    // DIV=8: reset at cnt=5 drops the pending tick and restarts the period.
    for (int c = 0; c < 20 && (m_n[2] % 8) != 5; c++) cyc();
    check_eq("div8.cnt5", m_n[2] % 8, 32'd5);
    rst_v[2] = 1'b1; cyc(); rst_v[2] = 1'b0;
    first8 = 0;
    for (int c = 1; c <= 12 && first8 == 0; c++) begin
      cyc();
      if (bus8.Tick === 1'b1) begin
        first8 = c;
        check_eq("div8.rst.Q", {28'd0, bus8.Q}, {28'd0, INIT_B});
      end
    end
    check_eq("div8.rst.first_tick", first8, 32'd8);

    // Randomized run with occasional per-instance resets.
    for (int c = 0; c < 400; c++) begin
      mode = 2'($urandom_range(0, 3));
      j    = 4'($urandom);
      k    = 4'($urandom);
      setn = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
      clrn = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
      for (int i = 0; i < 3; i++) rst_v[i] = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst_v = 3'b000;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
